spi_led_ctrl: RTL and testbench
===============================

SPI_LED_CTRL -- requirements
Module: spi_led_ctrl

Interface
REQ-001 SHALL have parameter PWM_PRESCALE, default 125: sysclk cycles per PWM step (125 MHz / 125 = 1 MHz step, 100 steps = 10 kHz PWM).
REQ-002 SHALL have parameter NUM_LEDS, default 4: number of LED channels, legal range 1..4.
REQ-003 SHALL have port sysclk, input, 1, single system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port frame_valid, input, 1, one-cycle pulse marking the slave's decoded frame as valid.
REQ-006 SHALL have port i_cmd, input, CMD_BITS (8), command field from the SPI slave.
REQ-007 SHALL have port i_addr, input, ADDR_BITS (8), address field from the SPI slave.
REQ-008 SHALL have port i_payload, input, PAYLOAD_BITS (8), data field from the SPI slave.
REQ-009 SHALL have port o_led, output, NUM_LEDS, PWM drive, active-high.
REQ-010 SHALL have port o_slv_frame, output, MASTER_FRAME_WIDTH (24), reply frame for the slave's i_slv_frame.
REQ-011 SHALL have port o_slv_tx_enb, output, 1, one-cycle strobe telling the slave to load o_slv_frame.
REQ-012 SHALL have port o_err, output, 1, one-cycle pulse on an illegal or dropped frame.

Function
REQ-013 SHALL sample i_cmd/i_addr/i_payload into holding registers on the cycle frame_valid=1 while in IDLE.
REQ-014 SHALL implement FSM IDLE -> DECODE -> {WRITE | READ | ERROR} -> IDLE, one cycle per state, for 3 cycles from capture back to IDLE.
REQ-015 SHALL decode cmd 8'h80 as WRITE and 8'h40 as READ; any other cmd value goes to ERROR.
REQ-016 SHALL accept addresses 8'hA0 to 8'hA0+NUM_LEDS-1 (channel = addr[1:0]); any other address goes to ERROR regardless of cmd.
REQ-017 WRITE SHALL load the channel's shadow duty register with min(payload, 100); values 101..255 saturate to 100.
REQ-018 Shadow duty SHALL be copied to the active duty register only at a PWM period boundary (step counter wrapping 99->0), so no partial periods occur.
REQ-019 Two WRITEs to one channel within one PWM period SHALL leave the last value in the shadow register.
REQ-020 READ SHALL set o_slv_frame = {8'h40, addr, shadow duty} and pulse o_slv_tx_enb for one cycle in the READ state; o_slv_frame SHALL hold its value until the next READ.
REQ-021 ERROR SHALL pulse o_err for one cycle and change no duty register.
REQ-022 A frame_valid arriving outside IDLE SHALL be dropped and SHALL pulse o_err the following cycle; the in-flight frame SHALL complete normally.
REQ-023 The prescaler SHALL count 0..PWM_PRESCALE-1 and advance the step counter 0..99 on wrap.
REQ-024 o_led[n] SHALL be registered high when step < active duty[n]: duty 0 gives constant low, duty 100 gives constant high.

Reset
REQ-025 Asserting rst_n low at any time, including mid-FSM, SHALL immediately force IDLE, clear all duty, prescaler and step registers, and set o_led=0, o_slv_frame=0, o_slv_tx_enb=0, o_err=0.
REQ-026 The first frame_valid sampled after rst_n deasserts SHALL be accepted normally.

Configuration
REQ-027 Macro LED_READBACK_EN SHALL control READ support: when defined, READ behaves per REQ-020.
REQ-028 When LED_READBACK_EN is undefined, cmd 8'h40 SHALL decode as ERROR, and o_slv_frame and o_slv_tx_enb SHALL be tied to 0.

Verification
REQ-029 Write test: frame {80,A2,0A} -> after a period boundary, o_led[2] is high for 10 of 100 steps, other LEDs stay low.
REQ-030 Saturation test: frame {80,A1,C8} -> o_led[1] is constantly high; with LED_READBACK_EN, READ {40,A1,xx} returns o_slv_frame=24'h40A164 with a single o_slv_tx_enb pulse.
REQ-031 Illegal-frame test: frames {11,A0,50} and {80,B0,50} -> each gives one o_err pulse, and duties are unchanged.
REQ-032 Busy-drop test: frame_valid pulses on two consecutive cycles -> the first executes, the second is dropped and gives one o_err pulse.
REQ-033 Boundary test: write duty 50 mid-period -> o_led is unchanged until step wraps 99->0, then follows the new duty.
REQ-034 Reset test: assert rst_n in the DECODE state of a WRITE -> o_led=0, the duty register stays 0, and the FSM is in IDLE.

Source files
------------

// File: rtl/spi_led_ctrl.sv
// spi_led_ctrl: turns decoded SPI frames into per-channel PWM duty settings.
// A small FSM captures a frame, decodes it, and writes a shadow duty register.
// The shadow values move to the active registers only at a PWM period boundary.
// Optional build macro: LED_READBACK_EN adds the READ command (cmd 8'h40).
// READ returns the shadow duty in o_slv_frame. Without the macro, READ is an
// illegal command and the slave reply outputs are tied low.
`timescale 1ns/1ps
module spi_led_ctrl #(
  parameter int PWM_PRESCALE = 125,
  parameter int NUM_LEDS     = 4
) (
  input  logic                sysclk,
  input  logic                rst_n,
  input  logic                frame_valid,
  input  logic [7:0]          i_cmd,
  input  logic [7:0]          i_addr,
  input  logic [7:0]          i_payload,
  output logic [NUM_LEDS-1:0] o_led,
  output logic [23:0]         o_slv_frame,
  output logic                o_slv_tx_enb,
  output logic                o_err
);

  localparam int         PRE_W     = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam logic [7:0] CMD_WRITE = 8'h80;
  localparam logic [7:0] CMD_READ  = 8'h40;
  localparam logic [6:0] DUTY_MAX  = 7'd100;
  localparam logic [6:0] STEP_LAST = 7'd99;

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WRITE, S_READ, S_ERROR} state_t;

  state_t             state;
  logic [7:0]         cmd_q;
  logic [7:0]         addr_q;
  logic [7:0]         pay_q;
  logic [6:0]         shadow [NUM_LEDS];
  logic [6:0]         active [NUM_LEDS];
  logic [PRE_W-1:0]   pre_cnt;
  logic [6:0]         step;
  logic               pre_wrap;
  logic               addr_ok;
  logic [1:0]         ch;

  // Duty requests above 100 % clamp to full-on.
  function automatic logic [6:0] sat_duty(input logic [7:0] v);
    return (v > 8'd100) ? DUTY_MAX : v[6:0];
  endfunction

  assign ch       = addr_q[1:0];
  assign addr_ok  = (addr_q[7:2] == 6'b101000) && ({1'b0, ch} < 3'(NUM_LEDS));
  assign pre_wrap = (pre_cnt == PRE_W'(PWM_PRESCALE - 1));

`ifdef LED_READBACK_EN
  logic [6:0] rd_duty;

  // Select the shadow duty of the addressed channel for the READ reply.
  always_comb begin
    rd_duty = '0;
    for (int n = 0; n < NUM_LEDS; n++) begin
      if (ch == 2'(n)) rd_duty = shadow[n];
    end
  end
`else
  assign o_slv_frame  = '0;
  assign o_slv_tx_enb = 1'b0;
`endif

  // Frame FSM: capture, decode, then one action cycle; also flags dropped frames.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cmd_q  <= '0;
      addr_q <= '0;
      pay_q  <= '0;
      o_err  <= 1'b0;
      for (int n = 0; n < NUM_LEDS; n++) shadow[n] <= '0;
`ifdef LED_READBACK_EN
      o_slv_frame  <= '0;
      o_slv_tx_enb <= 1'b0;
`endif
    end else begin
      // A frame arriving while busy is discarded and reported next cycle.
      o_err <= frame_valid && (state != S_IDLE);
`ifdef LED_READBACK_EN
      o_slv_tx_enb <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (frame_valid) begin
            cmd_q  <= i_cmd;
            addr_q <= i_addr;
            pay_q  <= i_payload;
            state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (addr_ok && (cmd_q == CMD_WRITE)) begin
            state <= S_WRITE;
          end
`ifdef LED_READBACK_EN
          else if (addr_ok && (cmd_q == CMD_READ)) begin
            state        <= S_READ;
            o_slv_tx_enb <= 1'b1;
            o_slv_frame  <= {CMD_READ, addr_q, 1'b0, rd_duty};
          end
`endif
          else begin
            state <= S_ERROR;
            o_err <= 1'b1;
          end
        end
        S_WRITE: begin
          for (int n = 0; n < NUM_LEDS; n++) begin
            if (ch == 2'(n)) shadow[n] <= sat_duty(pay_q);
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // PWM timebase, period-boundary duty transfer and registered LED compare.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      step    <= '0;
      o_led   <= '0;
      for (int n = 0; n < NUM_LEDS; n++) active[n] <= '0;
    end else begin
      if (pre_wrap) begin
        pre_cnt <= '0;
        if (step == STEP_LAST) begin
          step <= '0;
          for (int n = 0; n < NUM_LEDS; n++) active[n] <= shadow[n];
        end else begin
          step <= step + 7'd1;
        end
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end
      for (int n = 0; n < NUM_LEDS; n++) o_led[n] <= (step < active[n]);
    end
  end

endmodule

// File: tb/tb_spi_led_ctrl.sv
// tb_spi_led_ctrl: directed bench for spi_led_ctrl with an event scoreboard.
// Expected o_err / o_slv_tx_enb events are queued as frames are sent and are
// matched as the DUT produces them. LED duty is checked by counting high
// cycles over one full PWM period. The bench honours LED_READBACK_EN.
`timescale 1ns/1ps
module tb_spi_led_ctrl;

  localparam int P   = 2;
  localparam int NL  = 4;
  localparam int PER = 100 * P;

  logic          sysclk = 1'b0;
  logic          rst_n;
  logic          frame_valid;
  logic [7:0]    i_cmd;
  logic [7:0]    i_addr;
  logic [7:0]    i_payload;
  logic [NL-1:0] o_led;
  logic [23:0]   o_slv_frame;
  logic          o_slv_tx_enb;
  logic          o_err;

  typedef struct packed {
    logic        is_rd;
    logic [23:0] frame;
  } ev_t;

  ev_t exp_q[$];
  int  nchk = 0;
  int  nerr = 0;
  int  cnt [NL];

  spi_led_ctrl #(.PWM_PRESCALE(P), .NUM_LEDS(NL)) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .frame_valid (frame_valid),
    .i_cmd       (i_cmd),
    .i_addr      (i_addr),
    .i_payload   (i_payload),
    .o_led       (o_led),
    .o_slv_frame (o_slv_frame),
    .o_slv_tx_enb(o_slv_tx_enb),
    .o_err       (o_err)
  );

  always #4 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    nchk++;
    assert (obs === req) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic monitor();
    ev_t e;
    if ((o_err === 1'b1) || (o_slv_tx_enb === 1'b1)) begin
      chk("evt_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("evt_kind", {30'd0, o_slv_tx_enb, o_err}, e.is_rd ? 32'd2 : 32'd1);
        if (e.is_rd) chk("rd_frame", {8'd0, o_slv_frame}, {8'd0, e.frame});
      end
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sysclk);
      #1;
      monitor();
    end
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d);
    i_cmd       = c;
    i_addr      = a;
    i_payload   = d;
    frame_valid = 1'b1;
    cyc(1);
    frame_valid = 1'b0;
  endtask

  task automatic push_err();
    ev_t e;
    e.is_rd = 1'b0;
    e.frame = 24'h0;
    exp_q.push_back(e);
  endtask

  task automatic push_rd(input logic [23:0] f);
    ev_t e;
    e.is_rd = 1'b1;
    e.frame = f;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    cyc(6);
    chk(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic measure(input int ncyc);
    for (int n = 0; n < NL; n++) cnt[n] = 0;
    for (int i = 0; i < ncyc; i++) begin
      cyc(1);
      for (int n = 0; n < NL; n++) cnt[n] += 32'(o_led[n]);
    end
  endtask

  task automatic check_duties(input string tag, input int d0, input int d1,
                              input int d2, input int d3);
    cyc(2 * PER);
    measure(PER);
    chk({tag, "_led0"}, 32'(cnt[0]), 32'(d0 * P));
    chk({tag, "_led1"}, 32'(cnt[1]), 32'(d1 * P));
    chk({tag, "_led2"}, 32'(cnt[2]), 32'(d2 * P));
    chk({tag, "_led3"}, 32'(cnt[3]), 32'(d3 * P));
  endtask

  initial begin
    bit ok;
    bit prev;
    int c3;

    rst_n       = 1'b0;
    frame_valid = 1'b0;
    i_cmd       = 8'h0;
    i_addr      = 8'h0;
    i_payload   = 8'h0;

    // Reset state
    cyc(3);
    chk("rst_led", 32'(o_led), 32'd0);
    chk("rst_frame", {8'd0, o_slv_frame}, 32'd0);
    chk("rst_txenb", 32'(o_slv_tx_enb), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);

    // First frame after reset release; duty 10 on channel 2
    rst_n = 1'b1;
    send(8'h80, 8'hA2, 8'h0A);
    drain("write_no_evt");
    check_duties("write", 0, 0, 10, 0);

    // Saturation: 200 clamps to 100
    send(8'h80, 8'hA1, 8'hC8);
    drain("sat_no_evt");
    check_duties("sat", 0, 100, 10, 0);

    // Readback (or illegal command when readback is not built in)
`ifdef LED_READBACK_EN
    push_rd(24'h40A164);
    send(8'h40, 8'hA1, 8'h00);
    drain("read_evt");
    chk("read_hold", {8'd0, o_slv_frame}, 32'h0040A164);
`else
    push_err();
    send(8'h40, 8'hA1, 8'h00);
    drain("read_is_err");
    chk("read_tied_frame", {8'd0, o_slv_frame}, 32'd0);
`endif

    // Illegal command, out-of-window address, address past last channel
    push_err();
    send(8'h11, 8'hA0, 8'h50);
    cyc(4);
    push_err();
    send(8'h80, 8'hB0, 8'h50);
    cyc(4);
    push_err();
    send(8'h80, 8'hA4, 8'h50);
    drain("illegal_evt");
    check_duties("illegal", 0, 100, 10, 0);

    // Back-to-back frame_valid: first executes, second dropped
    push_err();
    i_cmd       = 8'h80;
    i_addr      = 8'hA0;
    i_payload   = 8'h20;
    frame_valid = 1'b1;
    cyc(1);
    i_cmd       = 8'h80;
    i_addr      = 8'hA3;
    i_payload   = 8'h64;
    cyc(1);
    frame_valid = 1'b0;
    drain("busy_evt");
    check_duties("busy", 32, 100, 10, 0);

    // Boundary: write duty 50 to channel 3 mid-period
    ok   = 1'b0;
    prev = o_led[0];
    for (int i = 0; i < 2 * PER && !ok; i++) begin
      cyc(1);
      if (o_led[0] && !prev) ok = 1'b1;
      prev = o_led[0];
    end
    chk("bnd_sync1", 32'(ok), 32'd1);
    cyc(30 * P);
    send(8'h80, 8'hA3, 8'h32);
    ok   = 1'b0;
    c3   = 0;
    prev = o_led[0];
    for (int i = 0; i < 2 * PER && !ok; i++) begin
      cyc(1);
      if (o_led[0] && !prev) ok = 1'b1;
      else c3 += 32'(o_led[3]);
      prev = o_led[0];
    end
    chk("bnd_sync2", 32'(ok), 32'd1);
    chk("bnd_before_wrap", 32'(c3), 32'd0);
    chk("bnd_at_wrap", 32'(o_led[3]), 32'd1);
    measure(PER);
    chk("bnd_after_led3", 32'(cnt[3]), 32'(50 * P));
    chk("bnd_after_led0", 32'(cnt[0]), 32'(32 * P));
    drain("bnd_no_evt");

    // Reset while a WRITE sits in DECODE
    send(8'h80, 8'hA0, 8'h64);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_led", 32'(o_led), 32'd0);
    chk("mid_rst_err", 32'(o_err), 32'd0);
    chk("mid_rst_txenb", 32'(o_slv_tx_enb), 32'd0);
    chk("mid_rst_frame", {8'd0, o_slv_frame}, 32'd0);
    cyc(3);
    rst_n = 1'b1;
    push_err();
    send(8'h11, 8'hA0, 8'h00);
    drain("post_rst_idle");
    check_duties("post_rst", 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
